// File: rtl/map_engine_pkg.sv
// Shared types for the map_engine list-map accelerator (package map_pkg).
// Build option: MAP_ENGINE_SAT_EN selects saturating arithmetic in map_fn.
package map_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } map_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_UNWIND,
    ST_DONE
  } map_state_e;

  // Widest element the engine is built for; modules keep width-matched locals.
  localparam int ELEM_DATA_W = 64;
  localparam int ELEM_IDX_W  = 16;

  typedef struct packed {
    logic [ELEM_DATA_W-1:0] data;
    logic [ELEM_IDX_W-1:0]  idx;
  } element_t;

endpackage

// File: rtl/map_engine_fn.sv
// map_fn: FN_LAT-stage function pipeline carrying data, index and valid.
// Build option: MAP_ENGINE_SAT_EN makes add/sub/mul saturate as unsigned values.
module map_fn
  import map_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int FN_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] k,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx
);

  logic [DATA_W-1:0] f_data;

`ifdef MAP_ENGINE_SAT_EN
  logic [DATA_W:0]     sum_w;
  logic [2*DATA_W-1:0] prod_w;

  always_comb begin
    sum_w  = {1'b0, in_data} + {1'b0, k};
    prod_w = {{DATA_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, k};
    f_data = in_data;
    case (map_op_e'(op))
      OP_ADD:  f_data = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
      OP_SUB:  f_data = (in_data < k) ? '0 : in_data - k;
      OP_MUL:  f_data = (|prod_w[2*DATA_W-1:DATA_W]) ? '1 : prod_w[DATA_W-1:0];
      default: f_data = in_data;
    endcase
  end
`else
  always_comb begin
    f_data = in_data;
    case (map_op_e'(op))
      OP_ADD:  f_data = in_data + k;
      OP_SUB:  f_data = in_data - k;
      OP_MUL:  f_data = in_data * k;
      default: f_data = in_data;
    endcase
  end
`endif

  // The function is evaluated into stage 0; later stages only delay it.
  for (genvar gi = 0; gi < FN_LAT; gi++) begin : g_stage
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              valid_next;
    logic [DATA_W-1:0] data_next;
    logic [IDX_W-1:0]  idx_next;

    if (gi == 0) begin : g_head
      assign valid_next = in_valid;
      assign data_next  = f_data;
      assign idx_next   = in_idx;
    end else begin : g_body
      assign valid_next = g_stage[gi-1].valid_reg;
      assign data_next  = g_stage[gi-1].data_reg;
      assign idx_next   = g_stage[gi-1].idx_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        idx_reg   <= '0;
      end else if (en) begin
        valid_reg <= valid_next;
        data_reg  <= data_next;
        idx_reg   <= idx_next;
      end
    end
  end

  assign out_valid = g_stage[FN_LAT-1].valid_reg;
  assign out_data  = g_stage[FN_LAT-1].data_reg;
  assign out_idx   = g_stage[FN_LAT-1].idx_reg;

endmodule

// File: rtl/map_engine.sv
// map_engine: walks a source list tail-first onto a stack, then unwinds it head-first
// through map_fn as an ordered valid/ready stream. Build option: MAP_ENGINE_SAT_EN.
module map_engine
  import map_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH+1),
  parameter int FN_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_we,
  input  logic [IDX_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] src_wdata,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_len,
  output logic              start_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              done,
  output logic [IDX_W-1:0]  done_count,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);

  map_state_e        state_reg;
  map_op_e           op_reg;
  logic [DATA_W-1:0] k_reg;
  logic [IDX_W-1:0]  len_reg;
  logic [IDX_W-1:0]  walk_idx_reg;
  logic [IDX_W-1:0]  sp_reg;
  logic [IDX_W-1:0]  pop_cnt_reg;
  logic [IDX_W-1:0]  pop_idx_reg;
  logic              pop_valid_reg;
  logic [DATA_W-1:0] pop_data_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              done_reg;
  logic              err_reg;
  logic [IDX_W-1:0]  done_count_reg;

  logic [DATA_W-1:0] src_mem   [DEPTH];
  logic [DATA_W-1:0] stack_mem [DEPTH];

  logic             idle;
  logic             push;
  logic             pop;
  logic             en;
  logic             last_hs;
  logic [IDX_W-1:0] rd_addr_raw;
  logic [AW-1:0]    rd_addr;

  assign idle    = (state_reg == ST_IDLE);
  assign push    = (state_reg == ST_WALK);
  assign en      = !(out_valid && !out_ready);
  assign pop     = en && (state_reg == ST_UNWIND) && (pop_cnt_reg != len_reg);
  assign last_hs = out_valid && out_ready && (out_idx == len_reg - 1'b1);

  // The read register always holds the element the next WALK cycle pushes.
  assign rd_addr_raw = push ? walk_idx_reg - 1'b1 : start_len - 1'b1;
  assign rd_addr     = (rd_addr_raw < DEPTH_L) ? AW'(rd_addr_raw) : '0;

  always_ff @(posedge clk) begin
    if (src_we && idle && (src_addr < DEPTH_L))
      src_mem[AW'(src_addr)] <= src_wdata;
    rd_data_reg <= src_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (push)
      stack_mem[AW'(sp_reg)] <= rd_data_reg;
    if (pop)
      pop_data_reg <= stack_mem[AW'(sp_reg - 1'b1)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_ADD;
      k_reg          <= '0;
      len_reg        <= '0;
      walk_idx_reg   <= '0;
      sp_reg         <= '0;
      pop_cnt_reg    <= '0;
      pop_idx_reg    <= '0;
      pop_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      done_count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (en)
        pop_valid_reg <= pop;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (start_len > DEPTH_L) begin
              err_reg <= 1'b1;
            end else if (start_len == '0) begin
              state_reg      <= ST_DONE;
              done_reg       <= 1'b1;
              done_count_reg <= '0;
            end else begin
              state_reg      <= ST_WALK;
              len_reg        <= start_len;
              op_reg         <= map_op_e'(op);
              k_reg          <= k;
              walk_idx_reg   <= start_len - 1'b1;
              sp_reg         <= '0;
              pop_cnt_reg    <= '0;
              done_count_reg <= '0;
            end
          end
        end
        ST_WALK: begin
          sp_reg <= sp_reg + 1'b1;
          if (walk_idx_reg == '0)
            state_reg <= ST_UNWIND;
          else
            walk_idx_reg <= walk_idx_reg - 1'b1;
        end
        ST_UNWIND: begin
          if (pop) begin
            sp_reg      <= sp_reg - 1'b1;
            pop_idx_reg <= pop_cnt_reg;
            pop_cnt_reg <= pop_cnt_reg + 1'b1;
          end
          if (last_hs) begin
            state_reg      <= ST_DONE;
            done_reg       <= 1'b1;
            done_count_reg <= len_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && sp_reg == DEPTH_L));
  assert property (@(posedge clk) disable iff (rst) !(pop && sp_reg == '0));

  map_fn #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .FN_LAT (FN_LAT)
  ) u_fn (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (pop_valid_reg),
    .in_data   (pop_data_reg),
    .in_idx    (pop_idx_reg),
    .op        (op_reg),
    .k         (k_reg),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  assign start_ready = idle;
  assign done        = done_reg;
  assign done_count  = done_count_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_map_engine.sv
// Self-checking bench for map_engine: vector table, hand-written corner sequences and
// randomized runs against a list-level model. Honours MAP_ENGINE_SAT_EN when defined.
module tb_map_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 4;
  localparam int FL    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_we;
  logic [IW-1:0] src_addr;
  logic [DW-1:0] src_wdata;
  logic          start;
  logic [IW-1:0] start_len;
  logic          start_ready;
  logic [1:0]    op;
  logic [DW-1:0] k;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          done;
  logic [IW-1:0] done_count;
  logic          err;

  always #5 clk = ~clk;

  map_engine #(.DATA_W(DW), .DEPTH(DEPTH), .IDX_W(IW), .FN_LAT(FL)) u_dut (
    .clk(clk), .rst(rst), .src_we(src_we), .src_addr(src_addr), .src_wdata(src_wdata),
    .start(start), .start_len(start_len), .start_ready(start_ready), .op(op), .k(k),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .done(done), .done_count(done_count), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  int src_model [DEPTH];
  int got_data [$];
  int got_idx  [$];
  int first_c, last_c, done_c, done_cnt, err_cnt, done_pulses, sr_low;
  int st_v, st_d, st_i;

  typedef struct {
    int len;
    int opv;
    int kv;
    int s0;
    int s1;
    int e0;
    int e1;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // List-level reference: f applied with plain integer arithmetic, then clamped or wrapped.
  function automatic int model_f(input int opv, input int kv, input int x);
    int r;
    int m;
    m = 1 << DW;
    case (opv)
      0:       r = x + kv;
      1:       r = x - kv;
      2:       r = x * kv;
      default: r = x;
    endcase
`ifdef MAP_ENGINE_SAT_EN
    if (opv != 3) begin
      if (r >= m) r = m - 1;
      if (r < 0)  r = 0;
    end
`endif
    return ((r % m) + m) % m;
  endfunction

  task automatic load_src(input int addr, input int data);
    @(negedge clk);
    src_we    = 1'b1;
    src_addr  = IW'(addr);
    src_wdata = DW'(data);
    @(negedge clk);
    src_we = 1'b0;
    if (addr < DEPTH) src_model[addr] = data;
  endtask

  // rdy_mode: 0 always ready, 1 not ready on cycles lo..hi, 2 random.
  task automatic run(input int len, input int opv, input int kv, input int rdy_mode,
                     input int lo, input int hi, input int abort_n, input bit junk,
                     input int budget);
    bit prev_stall;
    int prev_d, prev_i;
    @(negedge clk);
    for (int w = 0; w < 20 && !start_ready; w++) @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start     = 1'b1;
    start_len = IW'(len);
    op        = 2'(opv);
    k         = DW'(kv);
    @(posedge clk);
    got_data.delete();
    got_idx.delete();
    first_c = -1; last_c = -1; done_c = -1; done_cnt = -1;
    err_cnt = 0; done_pulses = 0; sr_low = 0;
    st_v = 0; st_d = -1; st_i = -1;
    prev_stall = 1'b0; prev_d = 0; prev_i = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        start_len = IW'($urandom_range(0, DEPTH));
        op        = 2'($urandom_range(0, 3));
        k         = DW'($urandom);
        src_we    = 1'($urandom_range(0, 1));
        src_addr  = IW'($urandom_range(0, DEPTH - 1));
        src_wdata = DW'($urandom);
      end
      if (abort_n > 0 && got_data.size() == abort_n) break;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(c >= lo && c <= hi);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_d);
        check("stall_idx", out_idx, prev_i);
      end
      if (rdy_mode == 1 && c == hi) begin
        st_v = out_valid; st_d = out_data; st_i = out_idx;
      end
      if (!start_ready && !junk) sr_low++;
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (out_ready) begin
          got_data.push_back(int'(out_data));
          got_idx.push_back(int'(out_idx));
          last_c = c;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_i = out_idx;
      if (err) err_cnt++;
      if (done) begin
        done_pulses++;
        done_c   = c;
        done_cnt = done_count;
        break;
      end
    end
    start     = 1'b0;
    src_we    = 1'b0;
    out_ready = 1'b1;
    $display("run len=%0d op=%0d k=%0d outputs=%0d first=%0d last=%0d done_cycle=%0d count=%0d err=%0d",
             len, opv, kv, got_data.size(), first_c, last_c, done_c, done_cnt, err_cnt);
  endtask

  task automatic check_list(input string tag, input int len, input int opv, input int kv);
    check({tag, "_count"}, got_data.size(), len);
    for (int j = 0; j < got_data.size(); j++) begin
      check({tag, "_data"}, got_data[j], model_f(opv, kv, src_model[j]));
      check({tag, "_idx"}, got_idx[j], j);
    end
    check({tag, "_done_pulse"}, done_pulses, 1);
    check({tag, "_done_count"}, done_cnt, len);
  endtask

  initial begin
`ifdef MAP_ENGINE_SAT_EN
    vecs[0] = '{2, 2, 2,   200, 100, 255, 200};
    vecs[1] = '{2, 1, 250, 200, 100, 0,   0};
    vecs[2] = '{2, 0, 100, 200, 100, 255, 200};
    vecs[3] = '{2, 3, 77,  200, 100, 200, 100};
    vecs[4] = '{2, 0, 2,   255, 0,   255, 2};
`else
    vecs[0] = '{2, 2, 2,   200, 100, 144, 200};
    vecs[1] = '{2, 1, 250, 200, 100, 206, 106};
    vecs[2] = '{2, 0, 100, 200, 100, 44,  200};
    vecs[3] = '{2, 3, 77,  200, 100, 200, 100};
    vecs[4] = '{2, 0, 2,   255, 0,   1,   2};
`endif
    for (int i = 0; i < DEPTH; i++) src_model[i] = 0;

    rst = 1'b1; src_we = 1'b0; src_addr = '0; src_wdata = '0;
    start = 1'b0; start_len = '0; op = '0; k = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_done_count", done_count, 0);
    rst = 1'b0;

    // Basic map with exact timing.
    for (int i = 0; i < 6; i++) load_src(i, i);
    run(6, 0, 2, 0, 0, 0, 0, 1'b0, 60);
    check_list("basic", 6, 0, 2);
    for (int j = 0; j < got_data.size(); j++) check("basic_const", got_data[j], j + 2);
    check("basic_first", first_c, 9);
    check("basic_last", last_c, 14);
    check("basic_done_cycle", done_c, 15);

    // Backpressure on cycles 10..12.
    run(6, 0, 2, 1, 10, 12, 0, 1'b0, 60);
    check_list("bp", 6, 0, 2);
    check("bp_hold_valid", st_v, 1);
    check("bp_hold_data", st_d, 3);
    check("bp_hold_idx", st_i, 1);
    check("bp_done_cycle", done_c, 18);

    // Zero length.
    run(0, 0, 2, 0, 0, 0, 0, 1'b0, 20);
    check("len0_valid", first_c, -1);
    check("len0_done_pulse", done_pulses, 1);
    check("len0_done_count", done_cnt, 0);
    check("len0_done_cycle", done_c, 0);

    // Over-length start is rejected.
    run(9, 0, 2, 0, 0, 0, 0, 1'b0, 20);
    check("len9_err", err_cnt, 1);
    check("len9_done", done_pulses, 0);
    check("len9_start_ready", sr_low, 0);
    check("len9_valid", first_c, -1);

    // Out-of-range write is dropped.
    load_src(1, 55);
    load_src(9, 99);
    run(2, 3, 0, 0, 0, 0, 0, 1'b0, 60);
    check_list("oor", 2, 3, 0);
    if (got_data.size() == 2) check("oor_keep", got_data[1], 55);

    // Op/width vector table.
    for (int v = 0; v < 5; v++) begin
      load_src(0, vecs[v].s0);
      load_src(1, vecs[v].s1);
      run(vecs[v].len, vecs[v].opv, vecs[v].kv, 0, 0, 0, 0, 1'b0, 60);
      check("vec_count", got_data.size(), 2);
      if (got_data.size() == 2) begin
        check("vec_e0", got_data[0], vecs[v].e0);
        check("vec_e1", got_data[1], vecs[v].e1);
      end
      check("vec_done_count", done_cnt, 2);
    end

    // Reset during UNWIND after two outputs, then a clean rerun.
    for (int i = 0; i < DEPTH; i++) load_src(i, 10 * i + 1);
    run(6, 0, 1, 0, 0, 0, 2, 1'b0, 60);
    check("abort_outputs", got_data.size(), 2);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_idx", out_idx, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_done_count", done_count, 0);
    check("abort_start_ready", start_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(3, 0, 5, 0, 0, 0, 0, 1'b0, 60);
    check_list("rerun", 3, 0, 5);

    // Randomized runs with backpressure and ignored inputs while busy.
    for (int r = 0; r < 25; r++) begin
      int len, opv, kv;
      for (int i = 0; i < DEPTH; i++) load_src(i, int'($urandom_range(0, 255)));
      len = $urandom_range(1, DEPTH);
      opv = $urandom_range(0, 3);
      kv  = $urandom_range(0, 255);
      run(len, opv, kv, 2, 0, 0, 0, 1'b1, 300);
      check_list("rand", len, opv, kv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_engine.md
Name: map_engine

Overview:
- Parametrised list-map accelerator: applies a selectable unary function to every element of a source list held in local memory, emitting the mapped list as an ordered valid/ready stream.
- Two-phase traversal: WALK pushes source elements onto an internal continuation stack tail-first; UNWIND pops them head-first through a pipelined function unit.
- Sits between the list-memory loader and downstream consumers; generalises the fixed-depth, fixed-f (x+2) map to configurable width, depth, op and latency, with backpressure, length checking and done/count reporting.

Parameters:
- DATA_W, 32, element width in bits.
- DEPTH, 8, maximum list length; sizes the source memory and the stack.
- IDX_W, $clog2(DEPTH+1), width of length, index and count fields.
- FN_LAT, 2, function-unit pipeline stages, minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- src_we  in  1  source memory write strobe; honoured only in IDLE.
- src_addr  in  IDX_W  source write address, 0..DEPTH-1; out-of-range writes are dropped.
- src_wdata  in  DATA_W  source write data.
- start  in  1  start request; accepted when start && start_ready.
- start_len  in  IDX_W  list length, sampled on accept.
- start_ready  out  1  high only in IDLE.
- op  in  2  function select, sampled on accept: 0 x+k, 1 x-k, 2 x*k (low DATA_W bits), 3 x.
- k  in  DATA_W  function constant, sampled on accept.
- out_valid  out  1  mapped element valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  f(src[out_idx]).
- out_idx  out  IDX_W  element index, ascending from 0.
- done  out  1  one-cycle pulse at end of run.
- done_count  out  IDX_W  elements emitted; held until the next accept.
- err  out  1  one-cycle pulse when a start with start_len > DEPTH is rejected.

Behaviour:
- Reset: state IDLE, stack pointer 0, pipeline empty. Outputs: start_ready 1; out_valid, done and err 0; out_data, out_idx and done_count 0. Source memory is not cleared.
- States: IDLE -> WALK -> UNWIND -> DONE -> IDLE.
- IDLE, start accepted:
  - start_len = 0: go to DONE.
  - start_len > DEPTH: err pulse next cycle, stay in IDLE.
  - otherwise: go to WALK.
- Accept cycle is cycle 0.
- WALK: one push per cycle, reading src[len-1] down to src[0], cycles 1..len. Then go to UNWIND.
- UNWIND: one pop per cycle while the pipeline advances. Popped element j (j = 0..len-1) enters the function unit tagged with index j.
- Function unit: FN_LAT register stages. Output stage drives out_valid, out_data and out_idx.
- Stall rule: the pipeline and pops advance only when !(out_valid && !out_ready). During a stall out_data and out_idx hold stable and out_valid stays 1.
- Timing with out_ready held 1:
  - first out_valid at cycle len+1+FN_LAT;
  - last at cycle 2*len+FN_LAT;
  - stack empty when the last pop issues.
- DONE: entered once the last handshake has occurred (or directly when len=0). done pulses for one cycle with done_count = len, then return to IDLE.
- Arithmetic wraps modulo 2^DATA_W. Unsigned for mul.
- Input capture: start and src writes while busy are ignored; op and k changes after accept have no effect.
- Stack overflow and underflow cannot occur because len ≤ DEPTH. An internal assertion flags push at full or pop at empty.
- rst mid-run: immediate return to reset values; the in-flight list is discarded and no done pulse is produced.

Optional Feature:
- MAP_ENGINE_SAT_EN defined: ops 0–2 saturate as unsigned values.
  - Add clamps to 2^DATA_W-1.
  - Sub clamps to 0.
  - Mul clamps to 2^DATA_W-1 when any high product bit is set.
- Undefined: wrap-around arithmetic as above.

Decomposition:
- Package map_pkg:
  - map_op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_PASS);
  - map_state_e enum;
  - element_t struct {data, idx}.
- Sub-module map_fn, instantiated once:
  - FN_LAT-deep pipeline with enable input;
  - computes f and carries idx and valid;
  - owns the SAT_EN logic.
- Stack and source memory stay inline as arrays.

Test Plan:
- Basic map: src=0..5, len=6, op=0, k=2, FN_LAT=2, out_ready=1 -> out_data 2,3,4,5,6,7 with idx 0..5; first valid at cycle 9, last at cycle 14; done at cycle 15 with done_count 6.
- Backpressure: same run, out_ready low on cycles 10–12 -> out_data 3 held stable at idx 1 through the stall; full ordered sequence delivered, no loss or duplication; done_count 6.
- Edge lengths:
  - len=0 -> no out_valid, done pulse with count 0;
  - len=9 with DEPTH=8 -> err pulse, start_ready stays 1, no done.
- Op/width: DATA_W=8, src={200,100}, op=2, k=2 -> 144, 200 (wrap). With MAP_ENGINE_SAT_EN -> 255, 200. op=1, k=250 with SAT -> 0, 0.
- Reset mid-run: assert rst during UNWIND after 2 outputs -> all outputs at reset values immediately; a new start with len=3 runs cleanly from idx 0.
